// File: rtl/noise_est_pkg.sv
// noise_est_pkg: shared types and constants for the noise-estimation control FSM.
package noise_est_pkg;

  localparam int TOTAL_SAMPLES_DEF = 16;
  localparam int BLK_CNT_W         = 32;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    COLLECT    = 3'd1,
    WAIT_MEAN  = 3'd2,
    VAR_START  = 3'd3,
    VAR_RUN    = 3'd4,
    BLOCK_DONE = 3'd5
  } est_state_e;

endpackage

// File: rtl/noise_estimation_fsm_if.sv
// noise_estimation_fsm_if: handshake bundle between frame timing / datapath and the
// noise-estimation FSM. Status signals exist only when NOISE_EST_STATUS_EN is defined.
interface noise_estimation_fsm_if;
  import noise_est_pkg::*;

  logic                 start_of_frame;
  logic                 mean_ready;
  logic                 variance_ready;
  logic [BLK_CNT_W-1:0] blocks_per_frame;
  logic                 shift_en;
  logic                 noise_mean_en;
  logic                 shift_reg_rst_n;
  logic                 variance_start_of_data;
`ifdef NOISE_EST_STATUS_EN
  logic [BLK_CNT_W-1:0] block_idx;
  logic                 frame_done;

  modport master (
    output start_of_frame, mean_ready, variance_ready, blocks_per_frame,
    input  shift_en, noise_mean_en, shift_reg_rst_n, variance_start_of_data,
    input  block_idx, frame_done
  );

  modport slave (
    input  start_of_frame, mean_ready, variance_ready, blocks_per_frame,
    output shift_en, noise_mean_en, shift_reg_rst_n, variance_start_of_data,
    output block_idx, frame_done
  );
`else
  modport master (
    output start_of_frame, mean_ready, variance_ready, blocks_per_frame,
    input  shift_en, noise_mean_en, shift_reg_rst_n, variance_start_of_data
  );

  modport slave (
    input  start_of_frame, mean_ready, variance_ready, blocks_per_frame,
    output shift_en, noise_mean_en, shift_reg_rst_n, variance_start_of_data
  );
`endif

endinterface

// File: rtl/noise_est_counter.sv
// noise_est_counter: generic up-counter with synchronous clear (priority over enable),
// enable, and a terminal-count flag against a run-time terminal value.
module noise_est_counter
  import noise_est_pkg::*;
#(
  parameter int W = BLK_CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] term_i,
  output logic [W-1:0] cnt_o,
  output logic [W-1:0] nxt_o,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear wins over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign nxt_o = cnt_d;
  assign tc_o  = (cnt_q == term_i);

endmodule

// File: rtl/noise_estimation_fsm.sv
// noise_estimation_fsm: sequences sample collection, mean, variance replay and block
// counting for the per-block noise estimator. Outputs are registered and equal the
// Moore decode of the state/counters they accompany.
// Optional: define NOISE_EST_STATUS_EN to add block_idx and frame_done outputs.
module noise_estimation_fsm
  import noise_est_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int TOTAL_SAMPLES = TOTAL_SAMPLES_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  noise_estimation_fsm_if.slave ctl_if
);

  localparam int              SAMP_W    = $clog2(TOTAL_SAMPLES + 1);
  localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'(TOTAL_SAMPLES - 1);
  // Sample width only matters to the datapath; kept here so both sides share one value.
  localparam int              unused_data_width = DATA_WIDTH;

  est_state_e           state_q, state_d;
  logic                 samp_clr, samp_en, blk_clr, blk_en, tgt_load;
  logic [SAMP_W-1:0]    samp_cnt, samp_nxt;
  logic                 samp_tc;
  logic [BLK_CNT_W-1:0] blk_cnt, blk_nxt;
  logic                 blk_last;
  logic [BLK_CNT_W-1:0] blk_target_q;
  logic                 shift_en_q, mean_en_q, sr_rst_n_q, var_sod_q;
  logic                 unused_blk;

  noise_est_counter #(.W(SAMP_W)) u_samp_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (samp_clr),
    .en_i   (samp_en),
    .term_i (SAMP_LAST),
    .cnt_o  (samp_cnt),
    .nxt_o  (samp_nxt),
    .tc_o   (samp_tc)
  );

  // blk_last is high while the current block is the final one of the frame.
  noise_est_counter #(.W(BLK_CNT_W)) u_blk_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (blk_clr),
    .en_i   (blk_en),
    .term_i (blk_target_q - BLK_CNT_W'(1)),
    .cnt_o  (blk_cnt),
    .nxt_o  (blk_nxt),
    .tc_o   (blk_last)
  );

  assign unused_blk = ^{blk_nxt, blk_cnt};

  // Next-state and counter control; inputs outside their accepting state are ignored.
  always_comb begin
    state_d  = state_q;
    samp_clr = 1'b0;
    samp_en  = 1'b0;
    blk_clr  = 1'b0;
    blk_en   = 1'b0;
    tgt_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (ctl_if.start_of_frame) begin
          state_d  = COLLECT;
          samp_clr = 1'b1;
          blk_clr  = 1'b1;
          tgt_load = 1'b1;
        end
      end
      COLLECT: begin
        if (samp_tc) begin
          state_d  = WAIT_MEAN;
          samp_clr = 1'b1;
        end else begin
          samp_en = 1'b1;
        end
      end
      WAIT_MEAN: begin
        if (ctl_if.mean_ready) state_d = VAR_START;
      end
      VAR_START: begin
        state_d = ctl_if.variance_ready ? BLOCK_DONE : VAR_RUN;
      end
      VAR_RUN: begin
        // Replay continues until the whole block has been shifted out once more.
        samp_en = (samp_cnt < SAMP_LAST);
        if (ctl_if.variance_ready) state_d = BLOCK_DONE;
      end
      BLOCK_DONE: begin
        samp_clr = 1'b1;
        blk_en   = 1'b1;
        if (!blk_last) begin
          state_d = COLLECT;
        end else if (ctl_if.start_of_frame) begin
          // Back-to-back frame: restart directly without an IDLE cycle.
          state_d  = COLLECT;
          blk_clr  = 1'b1;
          tgt_load = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef NOISE_EST_STATUS_EN
  logic frame_done_q;
`endif

  // State, frame target and registered outputs decoded from the upcoming state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      blk_target_q <= BLK_CNT_W'(1);
      shift_en_q   <= 1'b0;
      mean_en_q    <= 1'b0;
      sr_rst_n_q   <= 1'b1;
      var_sod_q    <= 1'b0;
`ifdef NOISE_EST_STATUS_EN
      frame_done_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (tgt_load) begin
        blk_target_q <= (ctl_if.blocks_per_frame == '0) ? BLK_CNT_W'(1)
                                                         : ctl_if.blocks_per_frame;
      end
      shift_en_q <= (state_d == COLLECT) || (state_d == VAR_START) ||
                    ((state_d == VAR_RUN) && (samp_nxt < SAMP_LAST));
      mean_en_q  <= (state_d == COLLECT);
      sr_rst_n_q <= (state_d != BLOCK_DONE);
      var_sod_q  <= (state_d == VAR_START);
`ifdef NOISE_EST_STATUS_EN
      frame_done_q <= (state_d == BLOCK_DONE) && blk_last;
`endif
    end
  end

  assign ctl_if.shift_en               = shift_en_q;
  assign ctl_if.noise_mean_en          = mean_en_q;
  assign ctl_if.shift_reg_rst_n        = sr_rst_n_q;
  assign ctl_if.variance_start_of_data = var_sod_q;
`ifdef NOISE_EST_STATUS_EN
  assign ctl_if.block_idx  = blk_cnt;
  assign ctl_if.frame_done = frame_done_q;
`endif

endmodule

// File: tb/tb_noise_estimation_fsm.sv
// tb_noise_estimation_fsm: self-checking bench for noise_estimation_fsm.
// Honours NOISE_EST_STATUS_EN to also check block_idx and frame_done.
module tb_noise_estimation_fsm;

  localparam int TS = 16;

  // Output nibble {shift_en, noise_mean_en, shift_reg_rst_n, variance_start_of_data}
  localparam logic [3:0] O_IDLE = 4'b0010;
  localparam logic [3:0] O_COL  = 4'b1110;
  localparam logic [3:0] O_VS   = 4'b1011;
  localparam logic [3:0] O_VR   = 4'b1010;
  localparam logic [3:0] O_BD   = 4'b0000;

  typedef struct {
    int          rep;
    logic        sof;
    logic        mr;
    logic        vr;
    logic [31:0] bpf;
    logic [3:0]  exp;
    logic        fd;
    logic [31:0] bidx;
  } row_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  row_t tbl[$];
  row_t rq[$];

  always #5 clk = ~clk;

  noise_estimation_fsm_if bus_if ();

  noise_estimation_fsm #(
    .DATA_WIDTH    (8),
    .TOTAL_SAMPLES (TS)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .ctl_if (bus_if)
  );

  function automatic row_t mk(input int rep, input logic sof, input logic mr, input logic vr,
                              input logic [31:0] bpf, input logic [3:0] exp, input logic fd,
                              input logic [31:0] bidx);
    row_t r;
    r.rep = rep; r.sof = sof; r.mr = mr; r.vr = vr; r.bpf = bpf;
    r.exp = exp; r.fd = fd; r.bidx = bidx;
    return r;
  endfunction

  function automatic logic [3:0] outs();
    return {bus_if.shift_en, bus_if.noise_mean_en, bus_if.shift_reg_rst_n,
            bus_if.variance_start_of_data};
  endfunction

  function automatic logic rbit();
    return ($urandom_range(0, 3) == 0);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic s, input logic m, input logic v, input logic [31:0] b);
    bus_if.start_of_frame   = s;
    bus_if.mean_ready       = m;
    bus_if.variance_ready   = v;
    bus_if.blocks_per_frame = b;
  endtask

  // Called just after a rising edge; drives the row and checks mid-cycle.
  task automatic apply_row(input row_t r, input string nm);
    for (int i = 0; i < r.rep; i++) begin
      drive(r.sof, r.mr, r.vr, r.bpf);
      @(negedge clk);
      check(nm, 32'(outs()), 32'(r.exp));
`ifdef NOISE_EST_STATUS_EN
      check({nm, "_fd"}, 32'(bus_if.frame_done), 32'(r.fd));
      check({nm, "_idx"}, bus_if.block_idx, r.bidx);
`endif
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // Full frame of four blocks: mean_ready one cycle after collection, variance_ready
  // two cycles after mean_ready. Checked through pulse and window counts.
  task automatic full_frame();
    int n_win = 0, run = 0, len_ok = 0, n_vs = 0, n_rs = 0, n_fd = 0;
    int p, bk;
    drive(1'b1, 1'b0, 1'b0, 32'd4);
    @(posedge clk); #1;
    for (int c = 0; c < 4 * 21 + 3; c++) begin
      p  = c % 21;
      bk = c / 21;
      drive(1'b0, (bk < 4) && (p == 17), (bk < 4) && (p == 19), 32'($urandom_range(0, 9)));
      @(negedge clk);
      if (bus_if.shift_en && bus_if.noise_mean_en) begin
        run++;
      end else begin
        if (run > 0) begin
          n_win++;
          if (run == TS) len_ok++;
        end
        run = 0;
      end
      if (bus_if.variance_start_of_data) n_vs++;
      if (!bus_if.shift_reg_rst_n) n_rs++;
`ifdef NOISE_EST_STATUS_EN
      if (bus_if.frame_done) n_fd++;
`endif
      @(posedge clk); #1;
    end
    check("ff_collect_windows", n_win, 4);
    check("ff_window_len16", len_ok, 4);
    check("ff_var_sod_pulses", n_vs, 4);
    check("ff_sr_clear_pulses", n_rs, 4);
    check("ff_idle_after", 32'(outs()), 32'(O_IDLE));
`ifdef NOISE_EST_STATUS_EN
    check("ff_frame_done_once", n_fd, 1);
`else
    check("ff_frame_done_absent", n_fd, 0);
`endif
  endtask

  // Asynchronous reset in VAR_RUN, then a clean single-block frame.
  task automatic reset_mid_frame();
    apply_row(mk(1, 1, 0, 0, 2, O_IDLE, 0, 4), "ar_sof");
    apply_row(mk(TS, 0, 0, 0, 2, O_COL, 0, 0), "ar_collect");
    apply_row(mk(1, 0, 1, 0, 2, O_IDLE, 0, 0), "ar_wait_mean");
    apply_row(mk(1, 0, 0, 0, 2, O_VS, 0, 0), "ar_var_start");
    check("ar_in_var_run", 32'(outs()), 32'(O_VR));
    #2 rst = 1'b1;
    #1;
    check("ar_immediate", 32'(outs()), 32'(O_IDLE));
`ifdef NOISE_EST_STATUS_EN
    check("ar_immediate_idx", bus_if.block_idx, 32'd0);
`endif
    @(posedge clk); #1;
    apply_row(mk(2, 0, 1, 1, 5, O_IDLE, 0, 0), "ar_held");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    apply_row(mk(3, 0, 1, 1, 5, O_IDLE, 0, 0), "ar_quiet");
    apply_row(mk(1, 1, 0, 0, 1, O_IDLE, 0, 0), "ar2_sof");
    apply_row(mk(TS, 0, 0, 0, 3, O_COL, 0, 0), "ar2_collect");
    apply_row(mk(1, 0, 1, 0, 3, O_IDLE, 0, 0), "ar2_wait_mean");
    apply_row(mk(1, 0, 0, 0, 3, O_VS, 0, 0), "ar2_var_start");
    apply_row(mk(1, 0, 0, 1, 3, O_VR, 0, 0), "ar2_var_run");
    apply_row(mk(1, 0, 0, 0, 3, O_BD, 1, 0), "ar2_block_done");
    apply_row(mk(2, 0, 0, 0, 3, O_IDLE, 0, 1), "ar2_idle");
  endtask

  // Reference waveform built from a random frame plan: each block is TS collect
  // cycles, a mean wait, a variance replay of TS shifts cut short by variance_ready,
  // and one clear cycle. Handshakes in other phases are random noise.
  task automatic gen_random(input int nf);
    logic        chained = 1'b0;
    logic        last_blk;
    int unsigned sel = $urandom_range(0, 4);
    int unsigned nsel, eff;
    int          idle_idx = 0;
    int          n_idle, g1, g2;
    logic [3:0]  e;
    for (int f = 0; f < nf; f++) begin
      eff = (sel == 0) ? 1 : sel;
      if (!chained) begin
        n_idle = $urandom_range(1, 3);
        for (int i = 0; i < n_idle; i++) begin
          rq.push_back(mk(1, i == n_idle - 1, rbit(), rbit(),
                          (i == n_idle - 1) ? sel : $urandom_range(0, 9), O_IDLE, 0, idle_idx));
        end
      end
      nsel = $urandom_range(0, 4);
      for (int b = 0; b < int'(eff); b++) begin
        for (int i = 0; i < TS; i++)
          rq.push_back(mk(1, rbit(), rbit(), rbit(), $urandom_range(0, 9), O_COL, 0, b));
        g1 = $urandom_range(0, 3);
        for (int i = 0; i <= g1; i++)
          rq.push_back(mk(1, rbit(), i == g1, rbit(), $urandom_range(0, 9), O_IDLE, 0, b));
        g2 = $urandom_range(0, TS + 2);
        for (int j = 0; j <= g2; j++) begin
          e = (j == 0) ? O_VS : ((j < TS) ? O_VR : O_IDLE);
          rq.push_back(mk(1, rbit(), rbit(), j == g2, $urandom_range(0, 9), e, 0, b));
        end
        last_blk = (b == int'(eff) - 1);
        if (last_blk) chained = (f < nf - 1) && ($urandom_range(0, 2) == 0);
        rq.push_back(mk(1, last_blk ? chained : rbit(), rbit(), rbit(),
                        (last_blk && chained) ? nsel : $urandom_range(0, 9), O_BD, last_blk, b));
      end
      idle_idx = eff;
      sel      = nsel;
    end
    rq.push_back(mk(3, 0, 0, 0, 0, O_IDLE, 0, idle_idx));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'd0);
    #1;
    // Reset held with random inputs: outputs must sit at reset values.
    for (int i = 0; i < 4; i++) begin
      drive(1'($urandom), 1'($urandom), 1'($urandom), $urandom);
      @(negedge clk);
      check("reset_outs", 32'(outs()), 32'(O_IDLE));
`ifdef NOISE_EST_STATUS_EN
      check("reset_fd", 32'(bus_if.frame_done), 32'd0);
      check("reset_idx", bus_if.block_idx, 32'd0);
`endif
      @(posedge clk); #1;
    end
    drive(1'b0, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single block, then blocks_per_frame=0 with spurious handshakes and a mid-COLLECT sof.
    tbl.push_back(mk(3,  0, 0, 0, 1, O_IDLE, 0, 0));
    tbl.push_back(mk(1,  1, 0, 0, 1, O_IDLE, 0, 0));
    tbl.push_back(mk(TS, 0, 0, 0, 7, O_COL,  0, 0));
    tbl.push_back(mk(1,  0, 1, 0, 7, O_IDLE, 0, 0));
    tbl.push_back(mk(1,  0, 0, 0, 7, O_VS,   0, 0));
    tbl.push_back(mk(1,  0, 0, 1, 7, O_VR,   0, 0));
    tbl.push_back(mk(1,  0, 0, 0, 7, O_BD,   1, 0));
    tbl.push_back(mk(3,  0, 0, 0, 7, O_IDLE, 0, 1));
    tbl.push_back(mk(1,  1, 0, 0, 0, O_IDLE, 0, 1));
    tbl.push_back(mk(5,  0, 0, 0, 0, O_COL,  0, 0));
    tbl.push_back(mk(1,  1, 1, 1, 0, O_COL,  0, 0));
    tbl.push_back(mk(10, 0, 0, 0, 3, O_COL,  0, 0));
    tbl.push_back(mk(2,  1, 0, 1, 3, O_IDLE, 0, 0));
    tbl.push_back(mk(1,  0, 1, 0, 3, O_IDLE, 0, 0));
    tbl.push_back(mk(1,  0, 1, 0, 3, O_VS,   0, 0));
    tbl.push_back(mk(3,  0, 0, 0, 3, O_VR,   0, 0));
    tbl.push_back(mk(1,  0, 0, 1, 3, O_VR,   0, 0));
    tbl.push_back(mk(1,  0, 0, 0, 3, O_BD,   1, 0));
    tbl.push_back(mk(2,  0, 1, 1, 3, O_IDLE, 0, 1));
    foreach (tbl[k]) apply_row(tbl[k], $sformatf("table_row%0d", k));

    full_frame();
    reset_mid_frame();

    do_reset();
    gen_random(12);
    foreach (rq[k]) apply_row(rq[k], "random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
